// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, default datapath width and the queue entry layout.
// Latency: none; this package holds only types and constants.
// Backpressure: not applicable.
package alu_pkg;

    localparam logic [3:0] OP_ANDR = 4'b0000;
    localparam logic [3:0] OP_XORR = 4'b0001;
    localparam logic [3:0] OP_ORR  = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0011;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_ADD  = 4'b0110;
    localparam logic [3:0] OP_SUB  = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_EQ   = 4'b1001;
    localparam logic [3:0] OP_GT   = 4'b1010;
    localparam logic [3:0] OP_LT   = 4'b1011;
    localparam logic [3:0] OP_SHR  = 4'b1100;
    localparam logic [3:0] OP_SHL  = 4'b1101;
    localparam logic [3:0] OP_BIC  = 4'b1110;
    localparam logic [3:0] OP_NOT  = 4'b1111;

    localparam int W_DEFAULT = 8;

    // Entry layout at the default width; the queue rebuilds the same layout for other widths.
    typedef struct packed {
        logic [3:0]           opcode;
        logic [W_DEFAULT-1:0] carry;
        logic [W_DEFAULT-1:0] result;
        logic                 zero;
        logic                 wide;
    } alu_entry_t;

endpackage

// File: rtl/alu_sync_fifo.sv
// Generic first-word-fall-through FIFO with occupancy count and synchronous flush.
// Latency: a write is visible at the read port one cycle later; the head is combinational from storage.
// Backpressure: wr_rdy is !full from registered count only; a pop never frees a slot for a same-cycle write.
module alu_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     wr_vld,
    output logic                     wr_rdy,
    input  logic [WIDTH-1:0]         wr_dat,
    output logic                     rd_vld,
    input  logic                     rd_rdy,
    output logic [WIDTH-1:0]         rd_dat,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic             push;
    logic             pop;

    assign wr_rdy = (count != CW'(DEPTH));
    assign rd_vld = (count != '0);
    assign push   = wr_vld && wr_rdy;
    assign pop    = rd_rdy && rd_vld;
    assign rd_dat = mem[rptr];

    // Pointer and occupancy bookkeeping; flush wins over any concurrent push or pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    // Storage is deliberately left unreset; only the slot at the write pointer is touched.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wptr] <= wr_dat;
    end

endmodule

// File: rtl/alu_result_queue.sv
// Registered ALU output stage: tags each result with zero/wide flags and queues it for writeback.
// Latency: an accepted result reaches out_* one cycle later; head data falls through combinationally.
// Backpressure: in_ready drops when DEPTH entries are held; out_valid/in_ready come from registered count only.
module alu_result_queue
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = W_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [3:0]             in_opcode,
    input  logic [W-1:0]           in_result,
    input  logic [W-1:0]           in_carry,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [3:0]             out_opcode,
    output logic [W-1:0]           out_result,
    output logic [W-1:0]           out_carry,
    output logic                   out_zero,
    output logic                   out_wide,
    output logic [$clog2(DEPTH):0] count
);

    // Same field order as alu_entry_t, resized to this instance's width.
    typedef struct packed {
        logic [3:0]   opcode;
        logic [W-1:0] carry;
        logic [W-1:0] result;
        logic         zero;
        logic         wide;
    } entry_t;

    entry_t wr_entry;
    entry_t head;

    // Flags are frozen at push time so the consumer sees exactly what the ALU produced.
    always_comb begin
        wr_entry        = '0;
        wr_entry.opcode = in_opcode;
        wr_entry.carry  = in_carry;
        wr_entry.result = in_result;
        wr_entry.zero   = ({in_carry, in_result} == '0);
        wr_entry.wide   = (in_carry != '0);
    end

    alu_sync_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush  (flush),
        .wr_vld (in_valid),
        .wr_rdy (in_ready),
        .wr_dat (wr_entry),
        .rd_vld (out_valid),
        .rd_rdy (out_ready),
        .rd_dat (head),
        .count  (count)
    );

    // An empty queue presents all-zero outputs rather than stale storage contents.
    always_comb begin
        out_opcode = '0;
        out_result = '0;
        out_carry  = '0;
        out_zero   = 1'b0;
        out_wide   = 1'b0;
        if (out_valid) begin
            out_opcode = head.opcode;
            out_result = head.result;
            out_carry  = head.carry;
            out_zero   = head.zero;
            out_wide   = head.wide;
        end
    end

endmodule

// File: tb/tb_alu_result_queue.sv
module tb_alu_result_queue;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_opcode = '0;
    logic [7:0] in_result = '0;
    logic [7:0] in_carry = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_opcode;
    logic [7:0] out_result;
    logic [7:0] out_carry;
    logic       out_zero;
    logic       out_wide;
    logic [2:0] count;

    int n_checks = 0;
    int n_fail   = 0;

    alu_result_queue #(.DEPTH(4), .W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_result  (in_result),
        .in_carry   (in_carry),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_opcode (out_opcode),
        .out_result (out_result),
        .out_carry  (out_carry),
        .out_zero   (out_zero),
        .out_wide   (out_wide),
        .count      (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of what the ALU handed over.
    typedef struct {
        logic [3:0] op;
        logic [7:0] res;
        logic [7:0] car;
    } ent_t;
    ent_t q[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
        end else if (flush) begin
            q.delete();
        end else begin
            bit do_push, do_pop;
            do_push = in_valid && (q.size() < 4);
            do_pop  = out_ready && (q.size() > 0);
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back('{in_opcode, in_result, in_carry});
        end
    end

    // Every cycle, the DUT must match the model away from the active edge.
    always @(negedge clk) begin
        check("m_count", 32'(count), 32'(q.size()));
        check("m_out_valid", 32'(out_valid), 32'(q.size() != 0));
        check("m_in_ready", 32'(in_ready), 32'(q.size() < 4));
        if (q.size() != 0) begin
            check("m_opcode", 32'(out_opcode), 32'(q[0].op));
            check("m_result", 32'(out_result), 32'(q[0].res));
            check("m_carry", 32'(out_carry), 32'(q[0].car));
            check("m_zero", 32'(out_zero), 32'(q[0].car == 0 && q[0].res == 0));
            check("m_wide", 32'(out_wide), 32'(q[0].car != 0));
        end else begin
            check("m_empty_dat", 32'({out_opcode, out_result, out_carry, out_zero, out_wide}), 32'd0);
        end
    end

    task automatic step(input logic v, input logic [3:0] op, input logic [7:0] r, input logic [7:0] c,
                        input logic ordy, input logic fl);
        in_valid  = v;
        in_opcode = op;
        in_result = r;
        in_carry  = c;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset then idle
        #2 rst_n = 1'b0;
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_result", 32'(out_result), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        step(1'b0, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0);
        check("idle_count", 32'(count), 32'd0);
        check("idle_out_valid", 32'(out_valid), 32'd0);

        // ADD with carry-out
        step(1'b1, 4'b0110, 8'h2C, 8'h01, 1'b0, 1'b0);
        check("add_valid", 32'(out_valid), 32'd1);
        check("add_result", 32'(out_result), 32'h2C);
        check("add_wide", 32'(out_wide), 32'd1);
        check("add_zero", 32'(out_zero), 32'd0);
        check("add_count", 32'(count), 32'd1);
        step(1'b0, 4'h0, 8'h00, 8'h00, 1'b1, 1'b0);
        check("add_popped", 32'(count), 32'd0);

        // MUL zero then EQ
        step(1'b1, 4'b1000, 8'h00, 8'h00, 1'b0, 1'b0);
        step(1'b1, 4'b1001, 8'h01, 8'h00, 1'b0, 1'b0);
        check("mul_opcode", 32'(out_opcode), 32'h8);
        check("mul_zero", 32'(out_zero), 32'd1);
        check("mul_wide", 32'(out_wide), 32'd0);
        step(1'b0, 4'h0, 8'h00, 8'h00, 1'b1, 1'b0);
        check("eq_opcode", 32'(out_opcode), 32'h9);
        check("eq_zero", 32'(out_zero), 32'd0);
        check("eq_result", 32'(out_result), 32'h01);
        step(1'b0, 4'h0, 8'h00, 8'h00, 1'b1, 1'b0);

        // Fill to full across pointer wrap
        for (int i = 0; i < 4; i++)
            step(1'b1, 4'(i + 3), 8'hA0 + 8'(i), 8'(i), 1'b0, 1'b0);
        check("full_count", 32'(count), 32'd4);
        check("full_in_ready", 32'(in_ready), 32'd0);
        step(1'b1, 4'hF, 8'hEE, 8'hEE, 1'b0, 1'b0);
        check("full_ignored", 32'(count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("drain_result", 32'(out_result), 32'hA0 + 32'(i));
            check("drain_opcode", 32'(out_opcode), 32'(i + 3));
            step(1'b0, 4'h0, 8'h00, 8'h00, 1'b1, 1'b0);
        end
        check("drain_empty", 32'(out_valid), 32'd0);

        // Streaming at count=2
        step(1'b1, 4'h5, 8'hB0, 8'h00, 1'b0, 1'b0);
        step(1'b1, 4'h5, 8'hB1, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            logic [7:0] exp_head;
            exp_head = (i < 2) ? 8'hB0 + 8'(i) : 8'hC0 + 8'(i - 2);
            check("stream_head", 32'(out_result), 32'(exp_head));
            step(1'b1, 4'h4, 8'hC0 + 8'(i), 8'h00, 1'b1, 1'b0);
            check("stream_count", 32'(count), 32'd2);
        end
        check("stream_tail0", 32'(out_result), 32'hC8);
        step(1'b0, 4'h0, 8'h00, 8'h00, 1'b1, 1'b0);
        check("stream_tail1", 32'(out_result), 32'hC9);
        step(1'b0, 4'h0, 8'h00, 8'h00, 1'b1, 1'b0);

        // Flush with concurrent push
        for (int i = 0; i < 3; i++)
            step(1'b1, 4'h7, 8'hD0 + 8'(i), 8'hFF, 1'b0, 1'b0);
        check("preflush_count", 32'(count), 32'd3);
        step(1'b1, 4'hE, 8'hFF, 8'h00, 1'b0, 1'b1);
        check("flush_count", 32'(count), 32'd0);
        check("flush_valid", 32'(out_valid), 32'd0);
        step(1'b1, 4'h2, 8'h55, 8'h00, 1'b0, 1'b0);
        check("postflush_head", 32'(out_result), 32'h55);
        check("postflush_count", 32'(count), 32'd1);
        step(1'b0, 4'h0, 8'h00, 8'h00, 1'b1, 1'b0);

        // Asynchronous reset mid-stream
        for (int i = 0; i < 3; i++)
            step(1'b1, 4'h6, 8'hE0 + 8'(i), 8'h00, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_count", 32'(count), 32'd0);
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_result", 32'(out_result), 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        step(1'b0, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0);
        step(1'b0, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0);
        check("post_rst_count", 32'(count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
